// File: rtl/snoop_pkg.sv
// Shared definitions for the MSI snooping controller: line states, bus
// messages, receptor FSM encodings and the emitter's local op codes.
package snoop_pkg;

  // MSI line states; encoding 2'b11 is illegal and read as Invalid
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  // Bus messages seen on the snoop side
  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_RM   = 2'b01;
  localparam logic [1:0] BUS_WM   = 2'b10;
  localparam logic [1:0] BUS_INV  = 2'b11;

  // Receptor FSM
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOOKUP    = 2'b01,
    WRITEBACK = 2'b10,
    UPDATE    = 2'b11
  } fsm_e;

  // Local processor ops, shared with the emitter
  typedef enum logic [1:0] {
    RM = 2'b00,
    RH = 2'b01,
    WM = 2'b10,
    WH = 2'b11
  } local_op_e;

  // Fold the illegal encoding onto Invalid
  function automatic logic [1:0] norm_state(input logic [1:0] s);
    return (s == 2'b11) ? ST_I : s;
  endfunction

endpackage

// File: rtl/snoop_next_state.sv
// Combinational MSI transition for a snooped line:
// (line state, bus message, hit) -> (next state, abort, write-back).
module snoop_next_state
  import snoop_pkg::*;
(
  input  logic [1:0] i_LineState,
  input  logic [1:0] i_Message,
  input  logic       i_Hit,
  output logic [1:0] o_NextState,
  output logic       o_Abort,
  output logic       o_WriteBack
);

  logic [1:0] w_State;
  assign w_State = norm_state(i_LineState);

  // Misses and Invalid lines keep their state; only hits can move
  always_comb begin
    o_NextState = w_State;
    o_Abort     = 1'b0;
    o_WriteBack = 1'b0;
    if (i_Hit) begin
      if (w_State == ST_M) begin
        // Dirty copy: remote must retry after we flush it
        o_Abort     = 1'b1;
        o_WriteBack = 1'b1;
        o_NextState = (i_Message == BUS_RM) ? ST_S : ST_I;
      end else if (w_State == ST_S) begin
        if (i_Message == BUS_WM || i_Message == BUS_INV)
          o_NextState = ST_I;
      end
    end
  end

endmodule

// File: rtl/snoop_receptor.sv
// Snoop-side receiver of the MSI controller. Accepts bus messages, looks
// up a direct-mapped line-state table and commits the MSI transition,
// flushing Modified lines through a write-back handshake first.
// Optional: define SNOOP_STATS_EN to add hit / write-back counters.
module snoop_receptor
  import snoop_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_BusValid,
  input  logic [1:0]        i_BusMessage,
  input  logic [ADDR_W-1:0] i_BusAddress,
  output logic              o_BusReady,
  output logic              o_Abort,
  output logic              o_WriteBack,
  output logic [ADDR_W-1:0] o_WbAddress,
  input  logic              i_WbDone,
  output logic              o_Done,
`ifdef SNOOP_STATS_EN
  output logic [15:0]       o_SnoopHits,
  output logic [15:0]       o_WriteBacks,
`endif
  input  logic              i_LocalWe,
  input  logic [ADDR_W-1:0] i_LocalAddress,
  input  logic [1:0]        i_LocalState,
  output logic              o_LocalReady
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  fsm_e              r_Fsm;
  logic [1:0]        r_Msg;
  logic [ADDR_W-1:0] r_Addr;
  logic [1:0]        r_NewState;
  logic              r_Hit;
  logic              r_WriteBack;
  logic [ADDR_W-1:0] r_WbAddress;
  logic              r_Done;

  logic [TAG_W-1:0]  r_Tag   [LINES];
  logic [1:0]        r_State [LINES];

  logic [INDEX_W-1:0] w_Idx;
  logic [TAG_W-1:0]   w_Tag;
  logic [1:0]         w_LineState;
  logic               w_Hit;
  logic [1:0]         w_NextState;
  logic               w_NsAbort;
  logic               w_NsWriteBack;
  logic               w_BusAccept;
  logic               w_LocalAccept;
  logic [INDEX_W-1:0] w_LocalIdx;
  logic [TAG_W-1:0]   w_LocalTag;

  assign w_Idx       = r_Addr[INDEX_W-1:0];
  assign w_Tag       = r_Addr[ADDR_W-1:INDEX_W];
  assign w_LineState = norm_state(r_State[w_Idx]);
  assign w_Hit       = (r_Tag[w_Idx] == w_Tag) && (w_LineState != ST_I);

  assign w_LocalIdx  = i_LocalAddress[INDEX_W-1:0];
  assign w_LocalTag  = i_LocalAddress[ADDR_W-1:INDEX_W];

  snoop_next_state u_next (
    .i_LineState (w_LineState),
    .i_Message   (r_Msg),
    .i_Hit       (w_Hit),
    .o_NextState (w_NextState),
    .o_Abort     (w_NsAbort),
    .o_WriteBack (w_NsWriteBack)
  );

  // Message 00 is never handshaken; snoops beat local writes in IDLE
  assign w_BusAccept   = (r_Fsm == IDLE) && i_BusValid && (i_BusMessage != BUS_NONE);
  assign o_BusReady    = (r_Fsm == IDLE);
  assign o_LocalReady  = (r_Fsm == IDLE) && !i_BusValid;
  assign w_LocalAccept = o_LocalReady && i_LocalWe;

  // Abort must land in the lookup cycle itself, so it is decoded from the
  // lookup rather than registered a cycle late.
  assign o_Abort     = (r_Fsm == LOOKUP) && w_NsAbort;
  assign o_WriteBack = r_WriteBack;
  assign o_WbAddress = r_WbAddress;
  assign o_Done      = r_Done;

  // Snoop FSM: latch, look up, optionally flush, commit
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Fsm       <= IDLE;
      r_Msg       <= BUS_NONE;
      r_Addr      <= '0;
      r_NewState  <= ST_I;
      r_Hit       <= 1'b0;
      r_WriteBack <= 1'b0;
      r_WbAddress <= '0;
      r_Done      <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      case (r_Fsm)
        IDLE: begin
          if (w_BusAccept) begin
            r_Msg  <= i_BusMessage;
            r_Addr <= i_BusAddress;
            r_Fsm  <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_NewState <= w_NextState;
          r_Hit      <= w_Hit;
          if (w_NsWriteBack) begin
            r_WriteBack <= 1'b1;
            r_WbAddress <= r_Addr;
            r_Fsm       <= WRITEBACK;
          end else begin
            r_Done <= 1'b1;
            r_Fsm  <= UPDATE;
          end
        end
        WRITEBACK: begin
          if (i_WbDone) begin
            r_WriteBack <= 1'b0;
            r_Done      <= 1'b1;
            r_Fsm       <= UPDATE;
          end
        end
        UPDATE: begin
          r_Fsm <= IDLE;
        end
        default: r_Fsm <= IDLE;
      endcase
    end
  end

  // Line table: snoop commits in UPDATE, local writes only in IDLE,
  // so the two writers never collide.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int k = 0; k < LINES; k++) begin
        r_Tag[k]   <= '0;
        r_State[k] <= ST_I;
      end
    end else if ((r_Fsm == UPDATE) && r_Hit) begin
      r_State[w_Idx] <= r_NewState;
    end else if (w_LocalAccept) begin
      r_Tag[w_LocalIdx]   <= w_LocalTag;
      r_State[w_LocalIdx] <= i_LocalState;
    end
  end

`ifdef SNOOP_STATS_EN
  logic [15:0] r_SnoopHits;
  logic [15:0] r_WriteBacks;

  // Saturating statistics counters
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_SnoopHits  <= '0;
      r_WriteBacks <= '0;
    end else begin
      if ((r_Fsm == UPDATE) && r_Hit && (r_SnoopHits != 16'hFFFF))
        r_SnoopHits <= r_SnoopHits + 16'd1;
      if ((r_Fsm == WRITEBACK) && i_WbDone && (r_WriteBacks != 16'hFFFF))
        r_WriteBacks <= r_WriteBacks + 16'd1;
    end
  end

  assign o_SnoopHits  = r_SnoopHits;
  assign o_WriteBacks = r_WriteBacks;
`endif

endmodule
